// File: rtl/hazard_ctrl_pkg.sv
// Shared opcodes, FSM encodings and decode helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_XOR = 4'h3,
    OP_COM = 4'h4,
    OP_SLL = 4'h5,
    OP_SRL = 4'h6,
    OP_MUL = 4'h7,
    OP_LW  = 4'h8,
    OP_SW  = 4'h9,
    OP_BEQ = 4'hA
  } opcode_e;

  localparam logic [0:0] HZ_RUN = 1'b0;
  localparam logic [0:0] HZ_MUL = 1'b1;

  localparam int MUL_LAT_DEF = 3;

  // Shifts take their amount from the immediate and LW only reads the base
  // register, so rt never carries a live operand for them.
  function automatic logic uses_rt(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR,
      OP_COM, OP_MUL, OP_SW,  OP_BEQ: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder/EX-side information into the hazard controller and pipeline controls back out.
interface hazard_ctrl_if #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
);
  logic [3:0]      id_opcode;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [3:0]      ex_opcode;
  logic            ex_memRead;
  logic [RA_W-1:0] ex_rd;
  logic            ex_branch;
  logic            ex_zero;

  logic             pc_en;
  logic             pc_src;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_opcode, id_rs, id_rt, ex_opcode, ex_memRead, ex_rd, ex_branch, ex_zero,
    input  pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
           mul_busy, stall_count
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_opcode, ex_memRead, ex_rd, ex_branch, ex_zero,
    output pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
           mul_busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the register a load in EX is about to write.
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W        = 3,
  parameter int ZERO_REG_HW = 1
) (
  input  logic [3:0]      id_opcode,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            ex_memRead,
  input  logic [RA_W-1:0] ex_rd,
  output logic            load_use
);
  logic rs_hit, rt_hit, rd_zero;

  always_comb begin
    rs_hit   = (ex_rd == id_rs);
    rt_hit   = uses_rt(id_opcode) && (ex_rd == id_rt);
    rd_zero  = (ZERO_REG_HW != 0) && (ex_rd == '0);
    load_use = ex_memRead && (rs_hit || rt_hit) && !rd_zero;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, taken-branch flush, multi-cycle MUL freeze,
// plus a saturating count of PC-stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W        = 3,
  parameter int MUL_LAT     = MUL_LAT_DEF,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_HW = 1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int MW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [MW-1:0] MCNT_INIT = MW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam bit MUL_STALL = (MUL_LAT > 1);

  logic [0:0]       st, st_nxt;
  logic [MW-1:0]    mcnt, mcnt_nxt;
  logic [CNT_W-1:0] cnt;

  logic load_use, branch_taken, ex_is_mul;
  logic pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush;

  hazard_ctrl_load_use_detect #(
    .RA_W        (RA_W),
    .ZERO_REG_HW (ZERO_REG_HW)
  ) u_lud (
    .id_opcode  (hz.id_opcode),
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .ex_memRead (hz.ex_memRead),
    .ex_rd      (hz.ex_rd),
    .load_use   (load_use)
  );

  assign branch_taken = hz.ex_branch && hz.ex_zero;
  assign ex_is_mul    = (hz.ex_opcode == OP_MUL);

  always_comb begin
    pc_en       = 1'b1;
    pc_src      = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    st_nxt      = st;
    mcnt_nxt    = mcnt;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      st_nxt     = HZ_RUN;
      mcnt_nxt   = '0;
    end else if (st == HZ_RUN) begin
      if (branch_taken) begin
        pc_src     = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (ex_is_mul && MUL_STALL) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
        st_nxt      = HZ_MUL;
        mcnt_nxt    = MCNT_INIT;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end else begin
      // mcnt==0 is the release cycle: MUL leaves EX, so the next MUL seen in RUN is new.
      if (mcnt != '0) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
        mcnt_nxt    = mcnt - 1'b1;
      end else begin
        st_nxt = HZ_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= HZ_RUN;
      mcnt <= '0;
      cnt  <= '0;
    end else begin
      st   <= st_nxt;
      mcnt <= mcnt_nxt;
      if (!pc_en && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.pc_src      = pc_src;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_en     = idex_en;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.mul_busy    = !rst && (st == HZ_MUL);
  assign hz.stall_count = cnt;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit, 4-bit-opcode core.
- Sits beside the instruction decoder and drives the PC and pipeline-register enables and flushes.
- Resolves three cases:
  - load-use hazards, with a one-cycle bubble;
  - taken BEQ branches, by flushing IF/ID and ID/EX;
  - multi-cycle MUL, by freezing the front end while the multiplier occupies EX.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- RA_W, 3: register-address width.
- MUL_LAT, 3: total cycles a MUL occupies EX. Legal values are 1 or more; a value of 1 disables MUL stalling.
- CNT_W, 16: width of the stall performance counter.
- ZERO_REG_HW, 1: when 1, register 0 is hardwired and never causes a load-use hazard.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- id_opcode  in  4  opcode of the instruction in ID.
- id_rs  in  RA_W  first source register in ID.
- id_rt  in  RA_W  second source register in ID.
- ex_opcode  in  4  opcode of the instruction in EX.
- ex_memRead  in  1  the EX instruction is a load.
- ex_rd  in  RA_W  destination register of the EX instruction.
- ex_branch  in  1  the EX instruction is BEQ.
- ex_zero  in  1  ALU zero flag from EX.
- pc_en  out  1  PC register load enable.
- pc_src  out  1  1 selects the branch target.
- ifid_en  out  1  IF/ID register hold when 0.
- ifid_flush  out  1  IF/ID becomes NOP.
- idex_en  out  1  ID/EX register hold when 0.
- idex_flush  out  1  ID/EX becomes a bubble: wen=0, memWrite=0, branch=0.
- exmem_flush  out  1  EX/MEM receives a bubble.
- mul_busy  out  1  FSM is in state MUL.
- stall_count  out  CNT_W  number of cycles with pc_en=0.

Behaviour:
- Outputs are combinational from the current state and inputs. The state, mul counter and stall_count are registered on the clk rising edge.
- Default (no event): pc_en=1, ifid_en=1, idex_en=1, every flush=0, pc_src=0.
- While rst=1, outputs are forced to: pc_en=0, ifid_en=0, idex_en=0, ifid_flush=1, idex_flush=1, exmem_flush=0, mul_busy=0.
- On the clock edge with rst=1: state<=RUN, mcnt<=0, stall_count<=0. Reset mid-MUL abandons the MUL with no residual stall.
- id_uses_rt is decoded from id_opcode. It is 1 for ADD, SUB, AND, XOR, COM, MUL, SW and BEQ, and 0 for SLL, SRL and LW. Unknown opcodes give 0.
- load_use = ex_memRead & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)) & !(ZERO_REG_HW & ex_rd==0).
- branch_taken = ex_branch & ex_zero.
- ex_is_mul = (ex_opcode==MUL).
- FSM state RUN, with priority evaluated in this order:
  1. branch_taken: pc_src=1, ifid_flush=1, idex_flush=1, pc_en=1. Stay in RUN. Any simultaneous load_use is ignored.
  2. ex_is_mul & MUL_LAT>1: pc_en=0, ifid_en=0, idex_en=0, exmem_flush=1. Go to MUL with mcnt<=MUL_LAT-2.
  3. load_use: pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle. The LW advances to MEM, so the condition self-clears.
- FSM state MUL:
  - If mcnt!=0: same stall outputs as RUN case 2, and mcnt<=mcnt-1.
  - If mcnt==0: release cycle with default outputs, so the MUL advances to MEM. Next state is RUN.
  - load_use and branch_taken are ignored while in MUL; they cannot coexist with a MUL in EX.
- MUL timing:
  - MUL occupies EX for exactly MUL_LAT cycles and causes MUL_LAT-1 stall cycles.
  - Back-to-back MULs retrigger in RUN the cycle after release.
  - A MUL that enters EX the cycle after a release is a new instruction, never a re-count.
- stall_count increments on every non-reset cycle with pc_en=0 and saturates at all-ones (no wrap).

Decomposition:
- Shared define file, existing: opcode macros ADD…BEQ.
- Shared define file, additions: state encodings HZ_RUN=1'b0 and HZ_MUL=1'b1; default MUL_LAT.
- One combinational sub-module, load_use_detect: the id_uses_rt decode plus the register compare. Output load_use.
- The FSM, mcnt and stall_count live in hazard_ctrl.

Test Plan:
- Load-use: LW with ex_rd=3, ID=ADD with rs=3 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all defaults; stall_count=1.
- Zero register: LW with ex_rd=0, ID=ADD with rs=0, ZERO_REG_HW=1 → no stall. Also LW with rd=2, ID=SLL with rt=2, rs=5 → no stall (SLL does not use rt).
- Taken BEQ: ex_branch=1, ex_zero=1 with load_use also true → pc_src=1, ifid_flush=1, idex_flush=1, pc_en=1, no stall.
- Not-taken BEQ: ex_zero=0 → all defaults.
- MUL, MUL_LAT=3: MUL reaches EX → 2 cycles of pc_en=0 and exmem_flush=1 with mul_busy=1 on the second, then a release cycle of defaults; stall_count=2.
- Back-to-back MULs → 4 stall cycles total with a release cycle between the two groups.
- rst=1 during MUL's first stall cycle → next cycle state=RUN, mul_busy=0, stall_count=0. After rst drops, defaults resume.
- Saturation, CNT_W=4: force 20 load-use stalls → stall_count=15 and holds at 15.
